// File: rtl/hssl_cfg_pkg.sv
//------------------------------------------------------------------------------
// hssl_cfg_pkg - shared types and constants for the HSSL config register file. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package hssl_cfg_pkg;

   typedef enum logic [2:0] {
      SEC_CTRL  = 3'd0,
      SEC_KEY   = 3'd1,
      SEC_MASK  = 3'd2,
      SEC_ROUTE = 3'd3,
      SEC_CNTR  = 3'd4
   } sec_t;

   localparam int CTRL_IDX_LINK_EN = 0;
   localparam int CTRL_IDX_COMMIT  = 1;
   localparam int CTRL_IDX_INFO    = 2;

   localparam int              CNTR_W   = 32;
   localparam logic [CNTR_W-1:0] CNTR_MAX = {CNTR_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_DONE    = 2'd2
   } apb_state_t;

endpackage

`default_nettype wire

// File: rtl/hssl_evt_cntr.sv
//------------------------------------------------------------------------------
// hssl_evt_cntr - saturating event counter; clear wins, clear+event loads 1. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hssl_evt_cntr
   import hssl_cfg_pkg::*;
#(
   parameter int W = CNTR_W
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clr,
   input  logic         evt,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (clr) begin
         count <= W'(evt);
      end else if (evt && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/hssl_cfg_regs.sv
//------------------------------------------------------------------------------
// hssl_cfg_regs - APB3 config/stats registers; counters built only with HSSL_CFG_CNTRS_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hssl_cfg_regs
   import hssl_cfg_pkg::*;
#(
   parameter int NUM_LINKS   = 1,
   parameter int NUM_ENTRIES = 16,
   parameter int ROUTE_W     = 3,
   parameter int NUM_CNTRS   = 4,
   parameter int REG_SEC_LSB = 8,
   parameter int REG_NUM_LSB = 2
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           apb_psel_in,
   input  logic                           apb_penable_in,
   input  logic                           apb_pwrite_in,
   input  logic [39:0]                    apb_paddr_in,
   input  logic [31:0]                    apb_pwdata_in,
   output logic [31:0]                    apb_prdata_out,
   output logic                           apb_pready_out,
   output logic                           apb_pslverr_out,
   input  logic [NUM_CNTRS-1:0]           evt_in,
   output logic [NUM_LINKS-1:0]           link_en_out,
   output logic [32*NUM_ENTRIES-1:0]      key_out,
   output logic [32*NUM_ENTRIES-1:0]      mask_out,
   output logic [ROUTE_W*NUM_ENTRIES-1:0] route_out,
   output logic                           commit_busy_out
);

   localparam int IDX_W = REG_SEC_LSB - REG_NUM_LSB;
`ifdef HSSL_CFG_CNTRS_EN
   localparam int CNTRS_PRESENT = NUM_CNTRS;
`else
   localparam int CNTRS_PRESENT = 0;
`endif
   localparam logic [31:0] INFO_WORD = {8'(NUM_LINKS), 8'(NUM_ENTRIES),
                                        8'(CNTRS_PRESENT), 8'(ROUTE_W)};

   apb_state_t                   state, state_nxt;
   logic [2:0]                   sec;
   logic [IDX_W-1:0]             idx;
   logic                         access, wr_req, rd_req, wr_ok;
   logic                         err, rd_err;
   logic [31:0]                  rd_data, sel_key, sel_mask, sel_route, sel_cnt;
   logic [31:0]                  rd_data_q;
   logic                         commit_pend;
   logic [32*NUM_ENTRIES-1:0]    sh_key, sh_mask;
   logic [ROUTE_W*NUM_ENTRIES-1:0] sh_route;
   logic                         unused_bits;

   assign sec    = apb_paddr_in[REG_SEC_LSB +: 3];
   assign idx    = apb_paddr_in[REG_NUM_LSB +: IDX_W];
   assign access = apb_psel_in & apb_penable_in;
   assign wr_req = access &  apb_pwrite_in & (state == ST_IDLE);
   assign rd_req = access & ~apb_pwrite_in & (state == ST_IDLE);
   assign wr_ok  = wr_req & ~err;

   always_comb begin
      sel_key   = '0;
      sel_mask  = '0;
      sel_route = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (idx == IDX_W'(i)) begin
            sel_key   = sh_key[32*i +: 32];
            sel_mask  = sh_mask[32*i +: 32];
            sel_route = 32'(sh_route[ROUTE_W*i +: ROUTE_W]);
         end
      end
   end

`ifdef HSSL_CFG_CNTRS_EN
   logic [CNTR_W-1:0] cnt [NUM_CNTRS];

   for (genvar g = 0; g < NUM_CNTRS; g++) begin : g_cntr
      hssl_evt_cntr #(.W(CNTR_W)) u_cntr (
         .clk    (clk),
         .resetn (resetn),
         .clr    (wr_ok && (sec == SEC_CNTR) && (idx == IDX_W'(g))),
         .evt    (evt_in[g]),
         .count  (cnt[g])
      );
   end

   always_comb begin
      sel_cnt = '0;
      for (int i = 0; i < NUM_CNTRS; i++) begin
         if (idx == IDX_W'(i)) sel_cnt = cnt[i];
      end
   end

   assign unused_bits = ^{apb_paddr_in[39:REG_SEC_LSB+3], apb_paddr_in[REG_NUM_LSB-1:0]};
`else
   assign sel_cnt     = '0;
   assign unused_bits = ^{apb_paddr_in[39:REG_SEC_LSB+3], apb_paddr_in[REG_NUM_LSB-1:0],
                          evt_in, sel_cnt};
`endif

   // Address decode: read data and error for the current access, write or read.
   always_comb begin
      err     = 1'b0;
      rd_data = '0;
      case (sec)
         SEC_CTRL: begin
            if (idx == IDX_W'(CTRL_IDX_LINK_EN)) begin
               rd_data = 32'(link_en_out);
            end else if (idx == IDX_W'(CTRL_IDX_COMMIT)) begin
               rd_data = '0;
            end else if (idx == IDX_W'(CTRL_IDX_INFO)) begin
               rd_data = INFO_WORD;
               err     = apb_pwrite_in;
            end else begin
               err = 1'b1;
            end
         end
         SEC_KEY: begin
            err     = 32'(idx) >= 32'(NUM_ENTRIES);
            rd_data = sel_key;
         end
         SEC_MASK: begin
            err     = 32'(idx) >= 32'(NUM_ENTRIES);
            rd_data = sel_mask;
         end
         SEC_ROUTE: begin
            err     = 32'(idx) >= 32'(NUM_ENTRIES);
            rd_data = sel_route;
         end
`ifdef HSSL_CFG_CNTRS_EN
         SEC_CNTR: begin
            err     = 32'(idx) >= 32'(NUM_CNTRS);
            rd_data = sel_cnt;
         end
`endif
         default: err = 1'b1;
      endcase
      if (err) rd_data = '0;
   end

   always_comb begin
      state_nxt       = state;
      apb_pready_out  = 1'b0;
      apb_pslverr_out = 1'b0;
      case (state)
         ST_IDLE: begin
            if (access && apb_pwrite_in) begin
               apb_pready_out  = 1'b1;
               apb_pslverr_out = err;
            end else if (access) begin
               state_nxt = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: state_nxt = ST_DONE;
         ST_DONE: begin
            apb_pready_out  = 1'b1;
            apb_pslverr_out = rd_err;
            state_nxt       = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (!apb_psel_in) state_nxt = ST_IDLE;
   end

   assign apb_prdata_out  = rd_data_q;
   assign commit_busy_out = commit_pend;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         rd_data_q   <= '0;
         rd_err      <= 1'b0;
         commit_pend <= 1'b0;
         link_en_out <= '0;
         sh_key      <= '0;
         sh_mask     <= '0;
         sh_route    <= '0;
         key_out     <= '0;
         mask_out    <= '0;
         route_out   <= '0;
      end else begin
         state <= state_nxt;
         if (rd_req) begin
            rd_data_q <= rd_data;
            rd_err    <= err;
         end
         if (wr_ok && (sec == SEC_CTRL) && (idx == IDX_W'(CTRL_IDX_LINK_EN)))
            link_en_out <= apb_pwdata_in[NUM_LINKS-1:0];
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (wr_ok && (idx == IDX_W'(i))) begin
               if (sec == SEC_KEY)   sh_key[32*i +: 32]             <= apb_pwdata_in;
               if (sec == SEC_MASK)  sh_mask[32*i +: 32]            <= apb_pwdata_in;
               if (sec == SEC_ROUTE) sh_route[ROUTE_W*i +: ROUTE_W] <= apb_pwdata_in[ROUTE_W-1:0];
            end
         end
         // Commit lands one edge after the write so the whole shadow moves at once.
         commit_pend <= wr_ok && (sec == SEC_CTRL) && (idx == IDX_W'(CTRL_IDX_COMMIT))
                        && apb_pwdata_in[0];
         if (commit_pend) begin
            key_out   <= sh_key;
            mask_out  <= sh_mask;
            route_out <= sh_route;
         end
      end
   end

endmodule

`default_nettype wire
